// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mc_pkg;

  // FETCH must encode as 0 so the debug state output reads 0 in reset.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  // Default MIPS opcode encodings.
  localparam logic [5:0] OP_R_DEF    = 6'b000000;
  localparam logic [5:0] OP_LW_DEF   = 6'b100011;
  localparam logic [5:0] OP_SW_DEF   = 6'b101011;
  localparam logic [5:0] OP_BEQ_DEF  = 6'b000100;
  localparam logic [5:0] OP_ADDI_DEF = 6'b001000;
  localparam logic [5:0] OP_J_DEF    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath control strobes decoded from the state.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  // States whose exit to FETCH retires an instruction.
  function automatic logic is_terminal(input state_t s);
    return (s == MEMWB) || (s == MEMWR) || (s == ALUWB) ||
           (s == BRANCH) || (s == ADDIWB) || (s == JUMP);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-path bundle between the multicycle controller and its datapath.
interface multicycle_controller_if #(
  parameter int OPW   = 6,
  parameter int CNT_W = 32
);
  logic [OPW-1:0]   opcode;
  logic             zero;
  logic             halt;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             pcen;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsrc;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;

  // Controller side.
  modport master (
    input  opcode, zero, halt, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, pcsrc, illegal, instret, state_o
  );

  // Datapath side.
  modport slave (
    output opcode, zero, halt, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, pcsrc, illegal, instret, state_o
  );
endinterface

// File: rtl/instret_counter.sv
// Wrapping retired-instruction counter.
module instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: plain binary increment, wrapping naturally at 2^CNT_W.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory handshake, fetch halt,
// sticky illegal-opcode trap and retired-instruction count.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int             OPW     = 6,
  parameter int             CNT_W   = 32,
  parameter logic [OPW-1:0] OP_R    = OP_R_DEF,
  parameter logic [OPW-1:0] OP_LW   = OP_LW_DEF,
  parameter logic [OPW-1:0] OP_SW   = OP_SW_DEF,
  parameter logic [OPW-1:0] OP_BEQ  = OP_BEQ_DEF,
  parameter logic [OPW-1:0] OP_ADDI = OP_ADDI_DEF,
  parameter logic [OPW-1:0] OP_J    = OP_J_DEF
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_controller_if.master  bus
);

  state_t           state_q, state_d;
  logic             fetch_issued_q, fetch_issued_d;
  logic             illegal_q, illegal_d;
  logic             inc;
  ctrl_t            ctrl, ctrl_o;
  logic [CNT_W-1:0] count;

  // Next-state, handshake tracking and per-state control decode.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    state_d        = state_q;
    fetch_issued_d = fetch_issued_q;
    ctrl           = '0;
    case (state_q)
      FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        // halt only gates a request that has not been raised yet.
        if (fetch_issued_q || !bus.halt) begin
          ctrl.mem_req = 1'b1;
          if (bus.mem_ready) begin
            ctrl.irwrite   = 1'b1;
            ctrl.pcen      = 1'b1;
            fetch_issued_d = 1'b0;
            state_d        = DECODE;
          end else begin
            fetch_issued_d = 1'b1;
          end
        end
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = FETCH;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = ALUWB;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.pcen    = bus.zero;
        state_d      = FETCH;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = ADDIWB;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        ctrl.pcsrc = PCSRC_JUMP;
        ctrl.pcen  = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    illegal_d = illegal_q || (state_d == TRAP);
    inc       = is_terminal(state_q) && (state_d == FETCH);
  end

  // State, handshake flag and sticky trap flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= FETCH;
      fetch_issued_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q        <= state_d;
      fetch_issued_q <= fetch_issued_d;
      illegal_q      <= illegal_d;
    end
  end

  instret_counter #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .count (count)
  );

  // Reset state is FETCH, which would otherwise drive mem_req; hold everything low in reset.
  assign ctrl_o = reset ? ctrl : '0;

  assign bus.mem_req  = ctrl_o.mem_req;
  assign bus.iord     = ctrl_o.iord;
  assign bus.memwrite = ctrl_o.memwrite;
  assign bus.irwrite  = ctrl_o.irwrite;
  assign bus.pcen     = ctrl_o.pcen;
  assign bus.regdst   = ctrl_o.regdst;
  assign bus.memtoreg = ctrl_o.memtoreg;
  assign bus.regwrite = ctrl_o.regwrite;
  assign bus.alusrca  = ctrl_o.alusrca;
  assign bus.alusrcb  = ctrl_o.alusrcb;
  assign bus.aluop    = ctrl_o.aluop;
  assign bus.pcsrc    = ctrl_o.pcsrc;
  assign bus.illegal  = illegal_q;
  assign bus.instret  = count;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPW(6), .CNT_W(32)) b ();
  multicycle_controller_if #(.OPW(6), .CNT_W(3))  b3 ();

  // The narrow-counter instance sees identical stimulus.
  assign b3.opcode    = b.opcode;
  assign b3.zero      = b.zero;
  assign b3.halt      = b.halt;
  assign b3.mem_ready = b.mem_ready;

  multicycle_controller #(.OPW(6), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  multicycle_controller #(.OPW(6), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                         S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8,
                         S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                         BAD = 6'b111111;

  // Strobe patterns {mem_req,iord,memwrite,irwrite,pcen,regdst,memtoreg,regwrite,alusrca}.
  localparam logic [8:0] ST_FGO   = 9'b100110000;
  localparam logic [8:0] ST_FWAIT = 9'b100000000;
  localparam logic [8:0] ST_NONE  = 9'b000000000;
  localparam logic [8:0] ST_ASA   = 9'b000000001;
  localparam logic [8:0] ST_MEMRD = 9'b110000000;
  localparam logic [8:0] ST_MEMWB = 9'b000000110;
  localparam logic [8:0] ST_MEMWR = 9'b111000000;
  localparam logic [8:0] ST_ALUWB = 9'b000001010;
  localparam logic [8:0] ST_BRT   = 9'b000010001;
  localparam logic [8:0] ST_ADWB  = 9'b000000010;
  localparam logic [8:0] ST_JUMP  = 9'b000010000;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic        halt;
    logic [19:0] exp;  // {state, strobes, alusrcb, aluop, pcsrc, illegal}
  } vec_t;

  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   irw_seen   = 0;

  function automatic vec_t row(input logic [5:0] op, input logic z, input logic rdy,
                               input logic hlt, input logic [3:0] st, input logic [8:0] strb,
                               input logic [1:0] asb, input logic [1:0] aop,
                               input logic [1:0] pcs);
    vec_t r;
    r.op   = op;
    r.zero = z;
    r.rdy  = rdy;
    r.halt = hlt;
    r.exp  = {st, strb, asb, aop, pcs, 1'b0};
    return r;
  endfunction

  function automatic logic [19:0] obs();
    return {b.state_o, b.mem_req, b.iord, b.memwrite, b.irwrite, b.pcen, b.regdst,
            b.memtoreg, b.regwrite, b.alusrca, b.alusrcb, b.aluop, b.pcsrc, b.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive each row just after a falling edge, compare 1 unit later, advance one cycle.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      b.opcode    = tbl[i].op;
      b.zero      = tbl[i].zero;
      b.mem_ready = tbl[i].rdy;
      b.halt      = tbl[i].halt;
      #1;
      check($sformatf("row%0d", i), 32'(obs()), 32'(tbl[i].exp));
      if (b.irwrite) irw_seen++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait lw, sw, add, addi, j: rows 0..19.
    tbl.push_back(row(LW, 0, 1, 0, S_FETCH,  ST_FGO,   2'b01, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_DECODE, ST_NONE,  2'b11, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMADR, ST_ASA,   2'b10, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMRD,  ST_MEMRD, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMWB,  ST_MEMWB, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(SW, 0, 1, 0, S_FETCH,  ST_FGO,   2'b01, 2'b00, 2'b00));
    tbl.push_back(row(SW, 0, 1, 0, S_DECODE, ST_NONE,  2'b11, 2'b00, 2'b00));
    tbl.push_back(row(SW, 0, 1, 0, S_MEMADR, ST_ASA,   2'b10, 2'b00, 2'b00));
    tbl.push_back(row(SW, 0, 1, 0, S_MEMWR,  ST_MEMWR, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(RT, 0, 1, 0, S_FETCH,  ST_FGO,   2'b01, 2'b00, 2'b00));
    tbl.push_back(row(RT, 0, 1, 0, S_DECODE, ST_NONE,  2'b11, 2'b00, 2'b00));
    tbl.push_back(row(RT, 0, 1, 0, S_EXEC,   ST_ASA,   2'b00, 2'b10, 2'b00));
    tbl.push_back(row(RT, 0, 1, 0, S_ALUWB,  ST_ALUWB, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(ADDI, 0, 1, 0, S_FETCH,  ST_FGO,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(ADDI, 0, 1, 0, S_DECODE, ST_NONE, 2'b11, 2'b00, 2'b00));
    tbl.push_back(row(ADDI, 0, 1, 0, S_ADDIEX, ST_ASA,  2'b10, 2'b00, 2'b00));
    tbl.push_back(row(ADDI, 0, 1, 0, S_ADDIWB, ST_ADWB, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 0, S_FETCH,  ST_FGO,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 0, S_DECODE, ST_NONE, 2'b11, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 0, S_JUMP,   ST_JUMP, 2'b00, 2'b00, 2'b10));
    // beq taken then not taken: rows 20..25.
    tbl.push_back(row(BEQ, 1, 1, 0, S_FETCH,  ST_FGO,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(BEQ, 1, 1, 0, S_DECODE, ST_NONE, 2'b11, 2'b00, 2'b00));
    tbl.push_back(row(BEQ, 1, 1, 0, S_BRANCH, ST_BRT,  2'b00, 2'b01, 2'b01));
    tbl.push_back(row(BEQ, 0, 1, 0, S_FETCH,  ST_FGO,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(BEQ, 0, 1, 0, S_DECODE, ST_NONE, 2'b11, 2'b00, 2'b00));
    tbl.push_back(row(BEQ, 0, 1, 0, S_BRANCH, ST_ASA,  2'b00, 2'b01, 2'b01));
    // lw with 3 fetch waits and 2 read waits, 10 cycles: rows 26..35.
    tbl.push_back(row(LW, 0, 0, 0, S_FETCH,  ST_FWAIT, 2'b01, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 0, 0, S_FETCH,  ST_FWAIT, 2'b01, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 0, 0, S_FETCH,  ST_FWAIT, 2'b01, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_FETCH,  ST_FGO,   2'b01, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_DECODE, ST_NONE,  2'b11, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMADR, ST_ASA,   2'b10, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 0, 0, S_MEMRD,  ST_MEMRD, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 0, 0, S_MEMRD,  ST_MEMRD, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMRD,  ST_MEMRD, 2'b00, 2'b00, 2'b00));
    tbl.push_back(row(LW, 0, 1, 0, S_MEMWB,  ST_MEMWB, 2'b00, 2'b00, 2'b00));
    // Halt before issue blocks; halt after issue is ignored: rows 36..42.
    tbl.push_back(row(J, 0, 1, 1, S_FETCH,  ST_NONE,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 1, S_FETCH,  ST_NONE,  2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 0, 0, S_FETCH,  ST_FWAIT, 2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 0, 1, S_FETCH,  ST_FWAIT, 2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 1, S_FETCH,  ST_FGO,   2'b01, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 1, S_DECODE, ST_NONE,  2'b11, 2'b00, 2'b00));
    tbl.push_back(row(J, 0, 1, 1, S_JUMP,   ST_JUMP,  2'b00, 2'b00, 2'b10));

    // Reset state: everything held low, including FETCH's own strobes.
    reset       = 1'b0;
    b.opcode    = '0;
    b.zero      = 1'b0;
    b.halt      = 1'b0;
    b.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_state",   32'(b.state_o), 32'(S_FETCH));
    check("rst_mem_req", 32'(b.mem_req), 32'd0);
    check("rst_irwrite", 32'(b.irwrite), 32'd0);
    check("rst_alusrcb", 32'(b.alusrcb), 32'd0);
    check("rst_illegal", 32'(b.illegal), 32'd0);
    check("rst_instret", b.instret, 32'd0);
    b.halt = 1'b1;
    reset  = 1'b1;
    @(negedge clk);

    run_rows(0, 19);
    #1 check("instret_after_5", b.instret, 32'd5);
    run_rows(20, 25);
    #1 check("instret_after_beq", b.instret, 32'd7);
    irw_seen = 0;
    run_rows(26, 35);
    #1 check("irwrite_pulses", 32'(irw_seen), 32'd1);
    check("instret_after_waitlw", b.instret, 32'd8);
    run_rows(36, 42);
    #1 check("instret_after_halt", b.instret, 32'd9);

    // Illegal opcode: DECODE then an absorbing TRAP.
    b.halt      = 1'b0;
    b.opcode    = BAD;
    b.mem_ready = 1'b1;
    #1 check("trap_fetch", 32'(b.state_o), 32'(S_FETCH));
    @(negedge clk);
    #1 check("trap_decode", {28'd0, b.state_o}, {28'd0, S_DECODE});
    check("trap_decode_illegal", 32'(b.illegal), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      b.mem_ready = i[0];
      #1;
      check($sformatf("trap_hold%0d", i),
            {22'd0, b.state_o, b.illegal, b.mem_req, b.regwrite, b.pcen, b.irwrite, b.memwrite},
            {22'd0, S_TRAP, 1'b1, 5'b00000});
      @(negedge clk);
    end
    #1 check("trap_instret", b.instret, 32'd9);
    reset = 1'b0;
    #1 check("trap_rst_illegal", 32'(b.illegal), 32'd0);
    check("trap_rst_state", 32'(b.state_o), 32'(S_FETCH));
    @(negedge clk);
    reset = 1'b1;

    // Nine jumps: wide counter reads 9, 3-bit counter wraps to 1.
    b.opcode    = J;
    b.mem_ready = 1'b1;
    repeat (27) @(negedge clk);
    #1 check("wrap_state", 32'(b.state_o), 32'(S_FETCH));
    check("wrap_wide",   b.instret, 32'd9);
    check("wrap_narrow", {29'd0, b3.instret}, 32'd1);

    // Asynchronous reset in the middle of MEMWB aborts the writeback.
    b.opcode = LW;
    repeat (4) @(negedge clk);
    #1 check("mid_memwb_state", 32'(b.state_o), 32'(S_MEMWB));
    check("mid_memwb_regwrite", 32'(b.regwrite), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_regwrite", 32'(b.regwrite), 32'd0);
    check("async_state",   32'(b.state_o), 32'(S_FETCH));
    check("async_instret", b.instret, 32'd0);
    check("async_instret3", {29'd0, b3.instret}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check("post_reset_instret", b.instret, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
